// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : memory_pkg
//  Brief   : Shared types and constants for the page-table backing memory.
//  Revision: 1.0 - initial release
// ============================================================================
package memory_pkg;

   localparam int DATA_W_DFLT      = 32;
   localparam int ADDR_W_DFLT      = 32;
   localparam int DEPTH_WORDS_DFLT = 1024;

   typedef enum logic [1:0] {
      IDLE        = 2'b00,
      READ_ACCESS = 2'b01,
      RESPOND     = 2'b10
   } state_t;

   localparam logic [31:0] ROOT_PT_BASE = 32'h0000_0400;
   localparam logic [31:0] L2_PT_BASE   = 32'h0000_0800;

   // Root entry 0 points at the L2 table; the rest are leaf/flag patterns.
   localparam logic [31:0] C_ROOT_PTE0 = 32'h0000_0801;
   localparam logic [31:0] C_ROOT_PTE1 = 32'h1234_0007;
   localparam logic [31:0] C_L2_PTE0   = 32'h1000_000F;
   localparam logic [31:0] C_L2_PTE1   = 32'h1100_000F;
   localparam logic [31:0] C_L2_PTE2   = 32'h1200_0007;

endpackage : memory_pkg
`default_nettype wire

// File: rtl/memory_array.sv
`default_nettype none
// ============================================================================
//  Module  : memory_array
//  Brief   : Combinational ROM lookup of the fixed page-table image.
//  Revision: 1.0 - initial release
// ============================================================================
module memory_array
   import memory_pkg::*;
#(
   parameter int DATA_W = DATA_W_DFLT,
   parameter int IDX_W  = 10
) (
   input  logic [IDX_W-1:0]  idx,
   output logic [DATA_W-1:0] data
);

   logic [31:0] w_byte_addr;
   logic [31:0] w_word;

   assign w_byte_addr = 32'({idx, 2'b00});

   always_comb begin
      w_word = '0;
      case (w_byte_addr)
         ROOT_PT_BASE:           w_word = C_ROOT_PTE0;
         ROOT_PT_BASE + 32'h4:   w_word = C_ROOT_PTE1;
         L2_PT_BASE:             w_word = C_L2_PTE0;
         L2_PT_BASE + 32'h4:     w_word = C_L2_PTE1;
         L2_PT_BASE + 32'h8:     w_word = C_L2_PTE2;
         default:                w_word = '0;
      endcase
   end

   assign data = DATA_W'(w_word);

endmodule : memory_array
`default_nettype wire

// File: rtl/memory.sv
`default_nettype none
// ============================================================================
//  Module  : memory
//  Brief   : Read-only page-table memory behind request/response handshakes.
//  Revision: 1.0 - initial release
// ============================================================================
module memory
   import memory_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DFLT,
   parameter int ADDR_W      = ADDR_W_DFLT,
   parameter int DEPTH_WORDS = DEPTH_WORDS_DFLT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_req_valid_i,
   output logic              mem_req_ready_o,
   input  logic [ADDR_W-1:0] mem_addr_i,
   output logic              mem_resp_valid_o,
   input  logic              mem_resp_ready_i,
   output logic [DATA_W-1:0] mem_data_o
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_t              state;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_data;

   logic [DATA_W-1:0]   w_rom_data;
   logic                w_in_range;
   logic                w_addr_unused;

   memory_array #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_array (
      .idx  (r_addr[IDX_W+1:2]),
      .data (w_rom_data)
   );

   // Anything above the byte window reads as zero rather than aliasing.
   assign w_in_range    = (r_addr[ADDR_W-1:IDX_W+2] == '0);
   assign w_addr_unused = ^r_addr[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_req_valid_i) begin
                  r_addr <= mem_addr_i;
                  state  <= READ_ACCESS;
               end
            end
            READ_ACCESS: begin
               r_data <= w_in_range ? w_rom_data : '0;
               state  <= RESPOND;
            end
            RESPOND: begin
               if (mem_resp_ready_i) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_req_ready_o  = (state == IDLE);
   assign mem_resp_valid_o = (state == RESPOND);
   assign mem_data_o       = r_data;

endmodule : memory
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
// ============================================================================
//  Module  : tb_memory
//  Brief   : Scoreboard bench for the page-table memory.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_memory;

   logic        clk;
   logic        rst;
   logic        mem_req_valid_i;
   logic        mem_req_ready_o;
   logic [31:0] mem_addr_i;
   logic        mem_resp_valid_o;
   logic        mem_resp_ready_i;
   logic [31:0] mem_data_o;

   typedef struct {
      logic [31:0] data;
      int          hs_cycle;
   } exp_t;

   exp_t sb_q[$];
   int   total;
   int   bad;
   int   cycle;
   logic prev_valid;
   logic prev_ready;

   memory dut (
      .clk              (clk),
      .rst              (rst),
      .mem_req_valid_i  (mem_req_valid_i),
      .mem_req_ready_o  (mem_req_ready_o),
      .mem_addr_i       (mem_addr_i),
      .mem_resp_valid_o (mem_resp_valid_o),
      .mem_resp_ready_i (mem_resp_ready_i),
      .mem_data_o       (mem_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the queue head.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
      end else begin
         if (prev_valid && !prev_ready)
            chk("resp_valid_held", {31'b0, mem_resp_valid_o}, 32'd1);
         if (mem_resp_valid_o) begin
            if (sb_q.size() == 0) begin
               chk("spurious_resp", 32'd1, 32'd0);
            end else begin
               if (!prev_valid)
                  chk("latency_edges", cycle - sb_q[0].hs_cycle, 32'd2);
               chk("resp_data", mem_data_o, sb_q[0].data);
               if (mem_resp_ready_i) void'(sb_q.pop_front());
            end
         end
         prev_valid = mem_resp_valid_o;
         prev_ready = mem_resp_ready_i;
      end
   end

   // hold_extra keeps req_valid asserted for cycles past acceptance.
   task automatic issue(input logic [31:0] addr, input logic [31:0] exp, input int hold_extra);
      exp_t e;
      bit   ok;
      ok = 0;
      @(negedge clk);
      mem_req_valid_i = 1'b1;
      mem_addr_i      = addr;
      for (int n = 0; n < 50; n++) begin
         if (mem_req_ready_o) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         chk("req_accept_timeout", 32'd0, 32'd1);
         mem_req_valid_i = 1'b0;
      end else begin
         e.data     = exp;
         e.hs_cycle = cycle;
         sb_q.push_back(e);
         @(posedge clk);
         repeat (hold_extra) @(posedge clk);
         #1 mem_req_valid_i = 1'b0;
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 100; n++) begin
         if (sb_q.size() == 0) return;
         @(negedge clk);
      end
      chk("drain_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
   endtask

   logic [31:0] zero_addrs [6] = '{32'h000, 32'h004, 32'h100, 32'hFFC, 32'h408, 32'h80C};
   logic [31:0] pt_addrs   [5] = '{32'h400, 32'h404, 32'h800, 32'h804, 32'h808};
   logic [31:0] pt_words   [5] = '{32'h0000_0801, 32'h1234_0007, 32'h1000_000F,
                                   32'h1100_000F, 32'h1200_0007};

   initial begin
      total            = 0;
      bad              = 0;
      rst              = 1'b1;
      mem_req_valid_i  = 1'b0;
      mem_addr_i       = '0;
      mem_resp_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_req_ready", {31'b0, mem_req_ready_o}, 32'd1);
      chk("reset_resp_valid", {31'b0, mem_resp_valid_o}, 32'd0);
      chk("reset_data", mem_data_o, 32'd0);

      foreach (zero_addrs[i]) issue(zero_addrs[i], 32'h0, 0);
      drain();
      foreach (pt_addrs[i]) issue(pt_addrs[i], pt_words[i], 0);
      drain();

      issue(32'h0000_1000, 32'h0, 0);
      issue(32'h0001_0000, 32'h0, 0);
      issue(32'h0000_0804, 32'h1100_000F, 1);
      drain();
      repeat (4) @(negedge clk);
      chk("held_req_single_resp", {31'b0, mem_resp_valid_o}, 32'd0);

      // Backpressure: response must sit stable until accepted.
      @(posedge clk); #1 mem_resp_ready_i = 1'b0;
      issue(32'h400, 32'h0000_0801, 0);
      for (int n = 0; n < 20 && !mem_resp_valid_o; n++) @(negedge clk);
      chk("bp_valid_seen", {31'b0, mem_resp_valid_o}, 32'd1);
      repeat (5) @(posedge clk);
      #1 mem_resp_ready_i = 1'b1;
      @(posedge clk);
      #1 mem_resp_ready_i = 1'b0;
      @(negedge clk);
      chk("bp_req_ready_after", {31'b0, mem_req_ready_o}, 32'd1);
      chk("bp_valid_after", {31'b0, mem_resp_valid_o}, 32'd0);
      chk("bp_data_kept", mem_data_o, 32'h0000_0801);

      mem_resp_ready_i = 1'b1;
      issue(32'h400, 32'h0000_0801, 0);
      issue(32'h800, 32'h1000_000F, 0);
      issue(32'h404, 32'h1234_0007, 0);
      drain();

      // Reset while in READ_ACCESS: no response may appear afterwards.
      @(negedge clk);
      mem_req_valid_i = 1'b1;
      mem_addr_i      = 32'h808;
      @(posedge clk);
      #1 mem_req_valid_i = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("abort_no_valid", {31'b0, mem_resp_valid_o}, 32'd0);
      end
      chk("abort_req_ready", {31'b0, mem_req_ready_o}, 32'd1);
      chk("abort_data_cleared", mem_data_o, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

endmodule : tb_memory
`default_nettype wire
